// File: rtl/rf_wb_arbiter_if.sv
// Write-back bus between the three requesters, the register-file write port and
// the decode-stage hazard check. The arbiter takes the slave side.
interface rf_wb_arbiter_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
);
  logic              WBA_hold;

  logic              REQ0_valid;
  logic              REQ1_valid;
  logic              REQ2_valid;
  logic [ADDR_W-1:0] REQ0_rd;
  logic [ADDR_W-1:0] REQ1_rd;
  logic [ADDR_W-1:0] REQ2_rd;
  logic [DATA_W-1:0] REQ0_wd;
  logic [DATA_W-1:0] REQ1_wd;
  logic [DATA_W-1:0] REQ2_wd;
  logic              REQ0_ready;
  logic              REQ1_ready;
  logic              REQ2_ready;

  logic              WB_EN;
  logic [ADDR_W-1:0] WB_WA;
  logic [DATA_W-1:0] WB_WD;

  logic [ADDR_W-1:0] HZ_ADDR1;
  logic [ADDR_W-1:0] HZ_ADDR2;
  logic              HZ_STALL;

  modport master (
    output WBA_hold,
    output REQ0_valid, REQ1_valid, REQ2_valid,
    output REQ0_rd, REQ1_rd, REQ2_rd,
    output REQ0_wd, REQ1_wd, REQ2_wd,
    input  REQ0_ready, REQ1_ready, REQ2_ready,
    input  WB_EN, WB_WA, WB_WD,
    output HZ_ADDR1, HZ_ADDR2,
    input  HZ_STALL
  );

  modport slave (
    input  WBA_hold,
    input  REQ0_valid, REQ1_valid, REQ2_valid,
    input  REQ0_rd, REQ1_rd, REQ2_rd,
    input  REQ0_wd, REQ1_wd, REQ2_wd,
    output REQ0_ready, REQ1_ready, REQ2_ready,
    output WB_EN, WB_WA, WB_WD,
    input  HZ_ADDR1, HZ_ADDR2,
    output HZ_STALL
  );
endinterface

// File: rtl/rf_wb_arbiter.sv
// Round-robin arbiter sharing the register-file write port among ALU, load and
// CSR/debug write-backs, with a registered write stage and RAW hazard detection.
module rf_wb_arbiter #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input logic            WBA_clk,
  input logic            WBA_rst,
  rf_wb_arbiter_if.slave bus
);

  logic [1:0]        ptr_q, ptr_d;
  logic              wbEn_q, wbEn_d;
  logic [ADDR_W-1:0] wbAddr_q, wbAddr_d;
  logic [DATA_W-1:0] wbData_q, wbData_d;

  logic [2:0]        reqValid;
  logic [1:0]        ptrEff;
  logic [2:0]        rotValid;
  logic [1:0]        grantOffset;
  logic [1:0]        grantIdx;
  logic              grantAny;
  logic [2:0]        grantVec;
  logic [ADDR_W-1:0] selRd;
  logic [DATA_W-1:0] selWd;
  logic              hit1, hit2;

  function automatic logic [1:0] addMod3(input logic [1:0] a, input logic [1:0] b);
    logic [2:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    if (sum >= 3'd3) begin
      sum = sum - 3'd3;
    end
    return sum[1:0];
  endfunction

  assign reqValid = {bus.REQ2_valid, bus.REQ1_valid, bus.REQ0_valid};

  // An illegal pointer value of 3 behaves exactly like 0.
  assign ptrEff = (ptr_q == 2'd3) ? 2'd0 : ptr_q;

  always_comb begin
    rotValid    = reqValid;
    grantOffset = 2'd0;
    grantAny    = 1'b0;
    grantVec    = 3'b000;
    case (ptrEff)
      2'd1:    rotValid = {reqValid[0], reqValid[2], reqValid[1]};
      2'd2:    rotValid = {reqValid[1], reqValid[0], reqValid[2]};
      default: rotValid = reqValid;
    endcase
    if (rotValid[0]) begin
      grantOffset = 2'd0;
    end else if (rotValid[1]) begin
      grantOffset = 2'd1;
    end else begin
      grantOffset = 2'd2;
    end
    grantIdx = addMod3(ptrEff, grantOffset);
    grantAny = (|rotValid) && !bus.WBA_hold && !WBA_rst;
    if (grantAny) begin
      grantVec = 3'b001 << grantIdx;
    end
  end

  assign bus.REQ0_ready = grantVec[0];
  assign bus.REQ1_ready = grantVec[1];
  assign bus.REQ2_ready = grantVec[2];

  always_comb begin
    selRd = bus.REQ0_rd;
    selWd = bus.REQ0_wd;
    case (grantIdx)
      2'd1: begin
        selRd = bus.REQ1_rd;
        selWd = bus.REQ1_wd;
      end
      2'd2: begin
        selRd = bus.REQ2_rd;
        selWd = bus.REQ2_wd;
      end
      default: begin
        selRd = bus.REQ0_rd;
        selWd = bus.REQ0_wd;
      end
    endcase
  end

  // Writes to x0 still consume the grant and advance the pointer, but never enable the port.
  always_comb begin
    ptr_d    = ptrEff;
    wbEn_d   = 1'b0;
    wbAddr_d = wbAddr_q;
    wbData_d = wbData_q;
    if (grantAny) begin
      ptr_d    = addMod3(grantIdx, 2'd1);
      wbEn_d   = (selRd != '0);
      wbAddr_d = selRd;
      wbData_d = selWd;
    end
  end

  always_ff @(posedge WBA_clk or posedge WBA_rst) begin
    if (WBA_rst) begin
      ptr_q    <= 2'd0;
      wbEn_q   <= 1'b0;
      wbAddr_q <= '0;
      wbData_q <= '0;
    end else begin
      ptr_q    <= ptr_d;
      wbEn_q   <= wbEn_d;
      wbAddr_q <= wbAddr_d;
      wbData_q <= wbData_d;
    end
  end

  assign bus.WB_EN = wbEn_q;
  assign bus.WB_WA = wbAddr_q;
  assign bus.WB_WD = wbData_q;

  // Pending requests count as hazards whether or not they win arbitration this cycle.
  always_comb begin
    hit1 = 1'b0;
    hit2 = 1'b0;
    if (bus.REQ0_valid && bus.REQ0_rd == bus.HZ_ADDR1) hit1 = 1'b1;
    if (bus.REQ1_valid && bus.REQ1_rd == bus.HZ_ADDR1) hit1 = 1'b1;
    if (bus.REQ2_valid && bus.REQ2_rd == bus.HZ_ADDR1) hit1 = 1'b1;
    if (wbEn_q && wbAddr_q == bus.HZ_ADDR1)            hit1 = 1'b1;
    if (bus.REQ0_valid && bus.REQ0_rd == bus.HZ_ADDR2) hit2 = 1'b1;
    if (bus.REQ1_valid && bus.REQ1_rd == bus.HZ_ADDR2) hit2 = 1'b1;
    if (bus.REQ2_valid && bus.REQ2_rd == bus.HZ_ADDR2) hit2 = 1'b1;
    if (wbEn_q && wbAddr_q == bus.HZ_ADDR2)            hit2 = 1'b1;
  end

  assign bus.HZ_STALL = !WBA_rst &&
                        ((hit1 && (bus.HZ_ADDR1 != '0)) || (hit2 && (bus.HZ_ADDR2 != '0)));

  grantOneHot: assert property (@(posedge WBA_clk) disable iff (WBA_rst) $onehot0(grantVec));
  ptrLegal:    assert property (@(posedge WBA_clk) disable iff (WBA_rst) ptr_q != 2'd3);

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Scoreboard bench for rf_wb_arbiter: directed requests push expected grants and
// register-file writes, a negedge monitor pops and compares them as they appear.
module tb_rf_wb_arbiter;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;

  logic WBA_clk = 1'b0;
  logic WBA_rst = 1'b1;

  rf_wb_arbiter_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

  rf_wb_arbiter #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .WBA_clk (WBA_clk),
    .WBA_rst (WBA_rst),
    .bus     (bus)
  );

  always #5 WBA_clk = ~WBA_clk;

  int checks = 0;
  int errors = 0;

  int                       expGrantQ[$];
  logic [ADDR_W+DATA_W-1:0] expWbQ[$];

  logic [2:0]               monReady;
  logic [2:0]               monExpVec;
  int                       monG;
  logic [ADDR_W+DATA_W-1:0] monWb;

  task automatic nextCycle();
    @(posedge WBA_clk);
    #1;
  endtask

  task automatic setReq(input int i, input logic v, input logic [ADDR_W-1:0] rd,
                        input logic [DATA_W-1:0] wd);
    case (i)
      0: begin bus.REQ0_valid = v; bus.REQ0_rd = rd; bus.REQ0_wd = wd; end
      1: begin bus.REQ1_valid = v; bus.REQ1_rd = rd; bus.REQ1_wd = wd; end
      default: begin bus.REQ2_valid = v; bus.REQ2_rd = rd; bus.REQ2_wd = wd; end
    endcase
  endtask

  task automatic applyStimulus(input logic hold, input logic [ADDR_W-1:0] a1,
                               input logic [ADDR_W-1:0] a2);
    bus.WBA_hold = hold;
    bus.HZ_ADDR1 = a1;
    bus.HZ_ADDR2 = a2;
  endtask

  task automatic expectGrant(input int g, input logic [ADDR_W-1:0] rd,
                             input logic [DATA_W-1:0] wd);
    expGrantQ.push_back(g);
    if (rd != '0) expWbQ.push_back({rd, wd});
  endtask

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=0x%0h expected=0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [2:0] readyVec();
    return {bus.REQ2_ready, bus.REQ1_ready, bus.REQ0_ready};
  endfunction

  // Monitor: every grant and every enabled write must match the next queued expectation.
  always @(negedge WBA_clk) begin
    if (!WBA_rst) begin
      monReady = readyVec();
      if (monReady != 3'b000) begin
        checks++;
        if (expGrantQ.size() == 0) begin
          errors++;
          $display("[TB] FAIL grant_unexpected ready=%b expected none at %0t", monReady, $time);
        end else begin
          monG      = expGrantQ.pop_front();
          monExpVec = 3'b001 << monG;
          if (monReady !== monExpVec) begin
            errors++;
            $display("[TB] FAIL grant ready=%b expected=%b at %0t", monReady, monExpVec, $time);
          end
        end
      end
      if (bus.WB_EN === 1'b1) begin
        checks++;
        if (expWbQ.size() == 0) begin
          errors++;
          $display("[TB] FAIL write_unexpected WA=%0d WD=0x%0h expected none at %0t",
                   bus.WB_WA, bus.WB_WD, $time);
        end else begin
          monWb = expWbQ.pop_front();
          if ({bus.WB_WA, bus.WB_WD} !== monWb) begin
            errors++;
            $display("[TB] FAIL write WA=%0d WD=0x%0h expected WA=%0d WD=0x%0h at %0t",
                     bus.WB_WA, bus.WB_WD, monWb[ADDR_W+DATA_W-1:DATA_W], monWb[DATA_W-1:0], $time);
          end
        end
      end
    end
  end

  initial begin
    #200000;
    errors++;
    $display("[TB] FAIL watchdog timeout reached, expected finish");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    setReq(0, 1'b1, 5'd3, 32'h0);
    setReq(1, 1'b0, 5'd0, 32'h0);
    setReq(2, 1'b0, 5'd0, 32'h0);
    applyStimulus(1'b0, 5'd3, 5'd0);

    // Reset: outputs cleared, combinational outputs gated even with a matching request.
    #12;
    checkOutput("rst_ready", 64'(readyVec()), 64'd0);
    checkOutput("rst_stall", 64'(bus.HZ_STALL), 64'd0);
    checkOutput("rst_wb_en", 64'(bus.WB_EN), 64'd0);
    checkOutput("rst_wb_wa", 64'(bus.WB_WA), 64'd0);
    checkOutput("rst_wb_wd", 64'(bus.WB_WD), 64'd0);
    nextCycle();
    WBA_rst = 1'b0;
    applyStimulus(1'b0, 5'd0, 5'd0);

    // Round-robin with all three continuously valid.
    setReq(0, 1'b1, 5'd1, 32'h100);
    setReq(1, 1'b1, 5'd2, 32'h200);
    setReq(2, 1'b1, 5'd3, 32'h300);
    for (int k = 0; k < 6; k++) begin
      expectGrant(k % 3, 5'(k % 3 + 1), 32'h100 * (k % 3 + 1));
      nextCycle();
    end

    // Single request on requester 1.
    setReq(0, 1'b0, 5'd0, 32'h0);
    setReq(2, 1'b0, 5'd0, 32'h0);
    setReq(1, 1'b1, 5'd5, 32'hDEADBEEF);
    expectGrant(1, 5'd5, 32'hDEADBEEF);
    nextCycle();
    setReq(1, 1'b0, 5'd0, 32'h0);
    nextCycle();
    @(negedge WBA_clk);
    checkOutput("single_en_off", 64'(bus.WB_EN), 64'd0);
    checkOutput("single_wa_hold", 64'(bus.WB_WA), 64'd5);
    checkOutput("single_wd_hold", 64'(bus.WB_WD), 64'hDEADBEEF);

    // Write to x0 from requester 2: granted, never enabled.
    nextCycle();
    setReq(2, 1'b1, 5'd0, 32'hAAAA5555);
    expectGrant(2, 5'd0, 32'hAAAA5555);
    nextCycle();
    setReq(2, 1'b0, 5'd0, 32'h0);
    @(negedge WBA_clk);
    checkOutput("x0_en", 64'(bus.WB_EN), 64'd0);
    checkOutput("x0_wa", 64'(bus.WB_WA), 64'd0);
    checkOutput("x0_wd", 64'(bus.WB_WD), 64'hAAAA5555);

    // Hold blocks grants, then REQ0 wins the first free cycle.
    nextCycle();
    applyStimulus(1'b1, 5'd0, 5'd0);
    setReq(0, 1'b1, 5'd9, 32'h1234);
    for (int k = 0; k < 3; k++) begin
      @(negedge WBA_clk);
      checkOutput("hold_ready", 64'(readyVec()), 64'd0);
      nextCycle();
    end
    applyStimulus(1'b0, 5'd0, 5'd0);
    expectGrant(0, 5'd9, 32'h1234);
    nextCycle();

    // Hazards while the rd=9 write sits in the output register and REQ0 waits on rd=7.
    applyStimulus(1'b1, 5'd7, 5'd0);
    setReq(0, 1'b1, 5'd7, 32'h77);
    @(negedge WBA_clk);
    checkOutput("hz_pending", 64'(bus.HZ_STALL), 64'd1);
    applyStimulus(1'b1, 5'd9, 5'd0);
    #1 checkOutput("hz_wb_reg", 64'(bus.HZ_STALL), 64'd1);
    applyStimulus(1'b1, 5'd8, 5'd0);
    #1 checkOutput("hz_no_match", 64'(bus.HZ_STALL), 64'd0);
    applyStimulus(1'b1, 5'd0, 5'd7);
    #1 checkOutput("hz_addr2", 64'(bus.HZ_STALL), 64'd1);
    nextCycle();
    applyStimulus(1'b1, 5'd9, 5'd0);
    #1 checkOutput("hz_wb_idle", 64'(bus.HZ_STALL), 64'd0);
    applyStimulus(1'b1, 5'd7, 5'd0);
    #1 checkOutput("hz_held", 64'(bus.HZ_STALL), 64'd1);
    nextCycle();
    applyStimulus(1'b0, 5'd7, 5'd0);
    expectGrant(0, 5'd7, 32'h77);
    @(negedge WBA_clk);
    checkOutput("hz_grant_N", 64'(bus.HZ_STALL), 64'd1);
    nextCycle();
    setReq(0, 1'b0, 5'd0, 32'h0);
    @(negedge WBA_clk);
    checkOutput("hz_N1", 64'(bus.HZ_STALL), 64'd1);
    nextCycle();
    @(negedge WBA_clk);
    checkOutput("hz_N2", 64'(bus.HZ_STALL), 64'd0);

    // Address 0 never stalls, even against a valid rd=0 request.
    nextCycle();
    applyStimulus(1'b1, 5'd0, 5'd0);
    setReq(2, 1'b1, 5'd0, 32'h22);
    @(negedge WBA_clk);
    checkOutput("hz_x0", 64'(bus.HZ_STALL), 64'd0);
    nextCycle();
    applyStimulus(1'b0, 5'd0, 5'd0);
    expectGrant(2, 5'd0, 32'h22);
    nextCycle();
    setReq(2, 1'b0, 5'd0, 32'h0);

    // Same rd from two requesters in consecutive grants: the later one is left behind.
    setReq(0, 1'b1, 5'd4, 32'hA);
    setReq(1, 1'b1, 5'd4, 32'hB);
    expectGrant(0, 5'd4, 32'hA);
    nextCycle();
    setReq(0, 1'b0, 5'd0, 32'h0);
    expectGrant(1, 5'd4, 32'hB);
    nextCycle();
    setReq(1, 1'b0, 5'd0, 32'h0);
    nextCycle();
    @(negedge WBA_clk);
    checkOutput("same_rd_wd", 64'(bus.WB_WD), 64'hB);

    // Reset mid-write: enable drops at once and arbitration restarts from requester 0.
    nextCycle();
    setReq(0, 1'b1, 5'd6, 32'h66);
    expectGrant(0, 5'd6, 32'h66);
    nextCycle();
    setReq(0, 1'b0, 5'd0, 32'h0);
    @(negedge WBA_clk);
    #2;
    WBA_rst = 1'b1;
    setReq(0, 1'b1, 5'd10, 32'hA0);
    setReq(2, 1'b1, 5'd12, 32'hC0);
    applyStimulus(1'b0, 5'd12, 5'd0);
    #1;
    checkOutput("midrst_en", 64'(bus.WB_EN), 64'd0);
    checkOutput("midrst_wa", 64'(bus.WB_WA), 64'd0);
    checkOutput("midrst_wd", 64'(bus.WB_WD), 64'd0);
    checkOutput("midrst_ready", 64'(readyVec()), 64'd0);
    checkOutput("midrst_stall", 64'(bus.HZ_STALL), 64'd0);
    nextCycle();
    expectGrant(0, 5'd10, 32'hA0);
    expectGrant(2, 5'd12, 32'hC0);
    WBA_rst = 1'b0;
    nextCycle();
    setReq(0, 1'b0, 5'd0, 32'h0);
    nextCycle();
    setReq(2, 1'b0, 5'd0, 32'h0);
    applyStimulus(1'b0, 5'd0, 5'd0);
    nextCycle();
    nextCycle();

    checkOutput("grant_queue_drained", 64'(expGrantQ.size()), 64'd0);
    checkOutput("write_queue_drained", 64'(expWbQ.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
